// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the CPU front end.
//   word_t           32-bit machine word
//   fetch_state_t    fetch sequencer states (IDLE, RUN, DRAIN)
//   RESET_PC_DEFAULT default boot address
//   NOP_INSTR        all-zero encoding (sll $0,$0,0) used as a filler word
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0040_0000;
    localparam word_t NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO of {instr, pc, pc+4} with flush.
// The head entry is read straight from flops, so the decoder-facing outputs
// are registered.
//   clk, rst_n            clock, async active-low reset
//   flush                 empty the FIFO (wins over push/pop)
//   push, push_instr,
//   push_pc, push_pc4     write one entry at the tail
//   pop                   drop the head entry (caller guarantees non-empty)
//   count                 occupancy 0..2
//   head_instr, head_pc,
//   head_pc4              head entry contents
module fetch_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_pc4,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic [31:0] head_pc4
);

    word_t instr_mem [2];
    word_t pc_mem    [2];
    word_t pc4_mem   [2];
    logic  wr_ptr;
    logic  rd_ptr;

    // When full with a simultaneous push and pop, wr_ptr == rd_ptr: the slot
    // being overwritten is exactly the one leaving, so no data is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
            pc4_mem[0]   <= '0;
            pc4_mem[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                pc4_mem[wr_ptr]   <= push_pc4;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];
    assign head_pc4   = pc4_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction-fetch stage. Owns the PC, handshakes with
// instruction memory (req/ready), buffers up to two words and hands them to
// decode under a valid/stall handshake. Redirects flush and restart fetch.
//   clk, rst_n                       clock, async active-low reset
//   imem_req, imem_addr              fetch request and word address
//   imem_ready, imem_rdata           request accepted / returned word
//   redirect_valid, redirect_pc      flush and restart at redirect_pc
//   stall                            decode cannot accept this cycle
//   instr_valid, instr_code,
//   instr_pc, pc_plus4               instruction presented to decode
//   fetch_err                        misaligned-fetch flag
// Build option: INSTR_FETCH_ALIGN_CHECK_EN turns a misaligned redirect target
// into a single nop entry flagged with fetch_err instead of masking bits [1:0].
module instr_fetch
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter int    BUF_DEPTH = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("instr_fetch: BUF_DEPTH must be 2");
        end
    endgenerate

    fetch_state_t state;
    fetch_state_t state_next;
    word_t        pc;
    word_t        drain_addr;
    word_t        addr_sel;
    word_t        redirect_target;
    logic [1:0]   count;
    logic [1:0]   occ_after_pop;
    logic         pop;
    logic         accept;
    logic         push_en;
    logic         err_push;
    logic         err_block;
    word_t        entry_instr;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic err_mode;
    logic err_sent;
    logic err_out;

    assign redirect_target = redirect_pc;
    assign err_block       = err_mode;
    assign err_push        = (state == RUN) && err_mode && !err_sent && !redirect_valid;
    assign fetch_err       = err_out;

    // A misaligned target parks the stage: one flagged nop is queued after
    // the redirect bubble and fetching stays blocked until the next redirect.
    // The buffer is always empty when that nop is queued, so one flag
    // register is enough to mark it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mode <= 1'b0;
            err_sent <= 1'b0;
            err_out  <= 1'b0;
        end else if (redirect_valid) begin
            err_mode <= |redirect_pc[1:0];
            err_sent <= 1'b0;
            err_out  <= 1'b0;
        end else if (err_push) begin
            err_sent <= 1'b1;
            err_out  <= 1'b1;
        end else if (pop) begin
            err_out  <= 1'b0;
        end
    end
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign err_block       = 1'b0;
    assign err_push        = 1'b0;
    assign fetch_err       = 1'b0;
`endif

    assign instr_valid   = (count != 2'd0);
    assign pop           = instr_valid && !stall;
    assign occ_after_pop = count - {1'b0, pop};

    // Requests are gated on occupancy after this cycle's pop. Once raised,
    // occupancy can only fall until ready, so req/addr stay stable. In DRAIN
    // the old request is kept up at its original address until it completes.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        addr_sel   = pc;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                imem_req = !err_block && (occ_after_pop < 2'd2);
                if (redirect_valid && imem_req && !imem_ready) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                addr_sel = drain_addr;
                if (imem_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr   = addr_sel & 32'hFFFF_FFFC;
    assign accept      = (state == RUN) && imem_req && imem_ready;
    assign push_en     = !redirect_valid && (accept || err_push);
    assign entry_instr = err_push ? NOP_INSTR : imem_rdata;

    // Redirect outranks the normal PC increment; words returned in the
    // redirect cycle or while draining are never pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
            if ((state == RUN) && (state_next == DRAIN)) begin
                drain_addr <= imem_addr;
            end
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push_en),
        .pop        (pop),
        .push_instr (entry_instr),
        .push_pc    (pc),
        .push_pc4   (pc + 32'd4),
        .count      (count),
        .head_instr (instr_code),
        .head_pc    (instr_pc),
        .head_pc4   (pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run checked against a
// stream-level model (expected next PC, memory content function, handshake
// and hold rules).
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_code;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // values observed during the most recent tick
    logic        o_req, o_rdy, o_valid, o_err;
    logic [31:0] o_addr, o_code, o_pc, o_pc4;

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr_code     (instr_code),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // memory content: a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Called just after a negedge: drive one cycle of inputs, answer the
    // memory request, capture outputs, then advance to the next negedge.
    task automatic tick(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        imem_ready = rdy && imem_req;
        imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        #1;
        o_req   = imem_req;
        o_rdy   = imem_ready;
        o_addr  = imem_addr;
        o_valid = instr_valid;
        o_code  = instr_code;
        o_pc    = instr_pc;
        o_pc4   = pc_plus4;
        o_err   = fetch_err;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr_code !== 32'h0) begin errors++; $display("[TB] FAIL reset_code: got %h expected 0", instr_code); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", instr_pc); end
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 0", pc_plus4); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", fetch_err); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, '0, 1);
        checks++; if (o_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", o_req); end
    endtask

    task automatic test_startup();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick(0, 0, '0, 1);
            if (c >= 1) begin
                checks++; if (o_req !== 1'b1 || o_addr !== RST_PC + 32'(4 * (c - 1))) begin
                    errors++; $display("[TB] FAIL startup_addr c%0d: got req %b addr %h expected req 1 addr %h", c, o_req, o_addr, RST_PC + 32'(4 * (c - 1)));
                end
            end
            checks++; if (o_valid !== (c >= 2)) begin errors++; $display("[TB] FAIL startup_valid c%0d: got %b expected %b", c, o_valid, c >= 2); end
            if (c >= 2) begin
                exp_pc = RST_PC + 32'(4 * (c - 2));
                checks++; if (o_pc !== exp_pc || o_pc4 !== exp_pc + 32'd4 || o_code !== mem_word(exp_pc)) begin
                    errors++; $display("[TB] FAIL startup_instr c%0d: got pc %h pc4 %h code %h expected pc %h pc4 %h code %h", c, o_pc, o_pc4, o_code, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, '0, 1);
            checks++; if (o_valid !== 1'b1 || o_pc !== RST_PC) begin errors++; $display("[TB] FAIL stall_hold k%0d: got valid %b pc %h expected valid 1 pc %h", k, o_valid, o_pc, RST_PC); end
            if (k >= 1) begin
                checks++; if (o_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req k%0d: got %b expected 0", k, o_req); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, '0, 1);
            checks++; if (o_valid !== 1'b1 || o_pc !== RST_PC + 32'(4 * k) || o_code !== mem_word(RST_PC + 32'(4 * k))) begin
                errors++; $display("[TB] FAIL stall_release k%0d: got valid %b pc %h expected valid 1 pc %h", k, o_valid, o_pc, RST_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        tick(0, 0, '0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, '0, 0);
            checks++; if (o_req !== 1'b1 || o_addr !== RST_PC || o_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL wait_stable k%0d: got req %b addr %h valid %b expected req 1 addr %h valid 0", k, o_req, o_addr, o_valid, RST_PC);
            end
        end
        tick(0, 0, '0, 1);
        checks++; if (o_req !== 1'b1 || o_addr !== RST_PC || o_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL wait_ready: got req %b addr %h valid %b expected req 1 addr %h valid 0", o_req, o_addr, o_valid, RST_PC);
        end
        tick(0, 0, '0, 0);
        checks++; if (o_valid !== 1'b1 || o_pc !== RST_PC || o_code !== mem_word(RST_PC)) begin
            errors++; $display("[TB] FAIL wait_latency: got valid %b pc %h code %h expected valid 1 pc %h code %h", o_valid, o_pc, o_code, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] tgt;
        tgt = 32'h0040_0100;
        do_reset();
        for (int c = 0; c < 4; c++) tick(0, 0, '0, 1);
        tick(0, 1, tgt, 0);
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h0040_000C) begin errors++; $display("[TB] FAIL drain_outstanding: got req %b addr %h expected req 1 addr 0040000c", o_req, o_addr); end
        tick(0, 0, '0, 0);
        checks++; if (o_req !== 1'b1 || o_addr !== 32'h0040_000C || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_hold: got req %b addr %h valid %b expected req 1 addr 0040000c valid 0", o_req, o_addr, o_valid); end
        tick(0, 0, '0, 1);
        checks++; if (o_addr !== 32'h0040_000C || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready: got addr %h valid %b expected addr 0040000c valid 0", o_addr, o_valid); end
        tick(0, 0, '0, 1);
        checks++; if (o_req !== 1'b1 || o_addr !== tgt || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_restart: got req %b addr %h valid %b expected req 1 addr %h valid 0", o_req, o_addr, o_valid, tgt); end
        tick(0, 0, '0, 1);
        checks++; if (o_valid !== 1'b1 || o_pc !== tgt || o_code !== mem_word(tgt)) begin errors++; $display("[TB] FAIL drain_first: got valid %b pc %h code %h expected valid 1 pc %h code %h", o_valid, o_pc, o_code, tgt, mem_word(tgt)); end
    endtask

    task automatic test_redirect_same();
        logic [31:0] tgt;
        tgt = 32'h0040_0200;
        do_reset();
        for (int c = 0; c < 3; c++) tick(0, 0, '0, 1);
        tick(0, 1, tgt, 1);
        checks++; if (o_valid !== 1'b1 || o_req !== 1'b1 || o_rdy !== 1'b1) begin errors++; $display("[TB] FAIL same_setup: got valid %b req %b ready %b expected 1 1 1", o_valid, o_req, o_rdy); end
        tick(0, 0, '0, 1);
        checks++; if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== tgt) begin errors++; $display("[TB] FAIL same_bubble: got valid %b req %b addr %h expected valid 0 req 1 addr %h", o_valid, o_req, o_addr, tgt); end
        tick(0, 0, '0, 1);
        checks++; if (o_valid !== 1'b1 || o_pc !== tgt) begin errors++; $display("[TB] FAIL same_resume: got valid %b pc %h expected valid 1 pc %h", o_valid, o_pc, tgt); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(0, 1, 32'hFFFF_FFF8, 0);
        tick(0, 0, '0, 1);
        checks++; if (o_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_a0: got %h expected fffffff8", o_addr); end
        tick(0, 0, '0, 1);
        checks++; if (o_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_a1: got %h expected fffffffc", o_addr); end
        tick(0, 0, '0, 1);
        checks++; if (o_addr !== 32'h0 || o_pc !== 32'hFFFF_FFFC || o_pc4 !== 32'h0) begin
            errors++; $display("[TB] FAIL wrap_a2: got addr %h pc %h pc4 %h expected addr 0 pc fffffffc pc4 0", o_addr, o_pc, o_pc4);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        for (int c = 0; c < 3; c++) tick(0, 0, '0, 1);
        tick(0, 1, 32'h0040_0102, 1);
        tick(0, 0, '0, 1);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        checks++; if (o_valid !== 1'b0 || o_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_bubble: got valid %b req %b expected 0 0", o_valid, o_req); end
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, '0, 1);
            checks++; if (o_valid !== 1'b1 || o_err !== 1'b1 || o_code !== 32'h0 || o_pc !== 32'h0040_0102 || o_req !== 1'b0) begin
                errors++; $display("[TB] FAIL mis_entry k%0d: got valid %b err %b code %h pc %h req %b expected 1 1 0 00400102 0", k, o_valid, o_err, o_code, o_pc, o_req);
            end
        end
        tick(1, 1, 32'h0040_0200, 1);
        tick(0, 0, '0, 1);
        checks++; if (o_err !== 1'b0 || o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0040_0200) begin
            errors++; $display("[TB] FAIL mis_clear: got err %b valid %b req %b addr %h expected 0 0 1 00400200", o_err, o_valid, o_req, o_addr);
        end
`else
        checks++; if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0040_0100) begin
            errors++; $display("[TB] FAIL mask_req: got valid %b req %b addr %h expected 0 1 00400100", o_valid, o_req, o_addr);
        end
        tick(0, 0, '0, 1);
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0040_0100 || o_err !== 1'b0) begin
            errors++; $display("[TB] FAIL mask_instr: got valid %b pc %h err %b expected 1 00400100 0", o_valid, o_pc, o_err);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, rpc, prev_addr, prev_pc;
        logic        st, rv, rdy, prev_req, prev_rdy, prev_valid, prev_stall, prev_rv;
        int          delivered;
        do_reset();
        exp_pc = RST_PC;
        delivered = 0;
        prev_req = 0; prev_rdy = 0; prev_valid = 0; prev_stall = 0; prev_rv = 0;
        prev_addr = '0; prev_pc = '0;
        for (int n = 0; n < 500; n++) begin
            st  = ($urandom_range(0, 99) < 30);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = RST_PC + ($urandom_range(0, 255) << 2);
            rdy = ($urandom_range(0, 99) < 65);
            tick(st, rv, rpc, rdy);
            if (o_req && o_addr[1:0] != 2'b00) begin
                checks++; errors++; $display("[TB] FAIL rnd_align n%0d: got addr %h expected low bits 00", n, o_addr);
            end
            if (prev_req && !prev_rdy) begin
                checks++; if (o_req !== 1'b1 || o_addr !== prev_addr) begin errors++; $display("[TB] FAIL rnd_req_stable n%0d: got req %b addr %h expected req 1 addr %h", n, o_req, o_addr, prev_addr); end
            end
            if (prev_valid && prev_stall && !prev_rv) begin
                checks++; if (o_valid !== 1'b1 || o_pc !== prev_pc) begin errors++; $display("[TB] FAIL rnd_hold n%0d: got valid %b pc %h expected valid 1 pc %h", n, o_valid, o_pc, prev_pc); end
            end
            if (o_valid) begin
                checks++; if (o_code !== mem_word(o_pc) || o_pc4 !== o_pc + 32'd4) begin
                    errors++; $display("[TB] FAIL rnd_content n%0d: got code %h pc4 %h expected code %h pc4 %h", n, o_code, o_pc4, mem_word(o_pc), o_pc + 32'd4);
                end
            end
            if (o_valid && !st) begin
                checks++; if (o_pc !== exp_pc) begin errors++; $display("[TB] FAIL rnd_order n%0d: got pc %h expected pc %h", n, o_pc, exp_pc); end
                exp_pc = o_pc + 32'd4;
                delivered++;
            end
            if (rv) exp_pc = rpc;
            checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err n%0d: got %b expected 0", n, o_err); end
            prev_req = o_req; prev_rdy = o_rdy; prev_addr = o_addr;
            prev_valid = o_valid; prev_stall = st; prev_rv = rv; prev_pc = o_pc;
        end
        checks++; if (delivered < 30) begin errors++; $display("[TB] FAIL rnd_progress: got %0d delivered expected at least 30", delivered); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_wait();
        test_redirect_drain();
        test_redirect_same();
        test_wrap();
        test_misaligned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
